// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port unified instruction/data memory between two
//   requesters: requester 0 (CPU) and requester 1 (DMA/debug loader). One
//   request is accepted at a time. For that request the arbiter drives the
//   memory address, write data and read/write strobes for exactly one cycle.
//   It then returns the registered read data with a one-cycle response pulse.
//   A transaction occupies IDLE -> ACCESS -> RESP, so at most one transaction
//   completes every three cycles.
//
// Handshake (valid/ready):
//   A requester raises i_reqN_valid and holds i_reqN_write, i_reqN_addr and
//   i_reqN_wdata stable until o_reqN_ready is seen high. The request
//   transfers on the rising edge where valid && ready are both 1. Ready is
//   combinational, is only asserted in IDLE, and is asserted for at most one
//   requester. After acceptance the requester-side fields are ignored because
//   the latched copy is used. The response is o_rspN_valid, a one-cycle pulse
//   with no back-pressure, two cycles after the accept edge.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN (macro) - when defined, a tie is granted to the
//                                requester that was not served last. When
//                                undefined, PRIO_REQ always wins a tie.
//
// Parameters:
//   ADDR_W   - address width; passed to the memory unchanged
//   DATA_W   - data width
//   PRIO_REQ - requester index that wins ties under fixed priority (0 or 1)
//
// Ports:
//   i_clk, i_reset              - clock; synchronous active-high reset
//   i_reqN_valid/write/addr/wdata, o_reqN_ready - request channel, N=0,1
//   o_rspN_valid, o_rspN_rdata  - response pulse and read data (0 for writes)
//   o_mem_addr/wdata/read/write - memory controls (0 outside ACCESS)
//   i_mem_rdata                 - combinational read data from memory
//   o_state                     - current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PRIO_REQ = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_req0_valid,
    input  logic              i_req0_write,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_req0_ready,

    input  logic              i_req1_valid,
    input  logic              i_req1_write,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req1_ready,

    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_rdata,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_rdata,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_write;
    logic              r_owner;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_grant;
`endif

    logic              w_winner;
    logic              w_accept;
    logic              w_in_access;
    logic              w_in_resp;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_write;

    // Winner selection. A lone valid requester always wins. Only a tie
    // consults the arbitration policy.
    always_comb begin
        w_winner = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = ~r_last_grant;
`else
            w_winner = (PRIO_REQ != 0);
`endif
        end else if (i_req1_valid) begin
            w_winner = 1'b1;
        end
    end

    // Reset masks ready so that no handshake can complete on a reset edge.
    assign w_accept     = (r_state == ST_IDLE) && (i_req0_valid || i_req1_valid) && !i_reset;
    assign o_req0_ready = w_accept && !w_winner;
    assign o_req1_ready = w_accept &&  w_winner;

    assign w_sel_addr  = w_winner ? i_req1_addr  : i_req0_addr;
    assign w_sel_wdata = w_winner ? i_req1_wdata : i_req0_wdata;
    assign w_sel_write = w_winner ? i_req1_write : i_req0_write;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_owner      <= 1'b0;
            r_rdata      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_write      <= w_sel_write;
                        r_owner      <= w_winner;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_winner;
`endif
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A write returns zero. The store lands in memory on this same edge.
                    r_rdata <= r_write ? '0 : i_mem_rdata;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and the response are masked by reset in the same cycle.
    // Asserting reset during ACCESS therefore prevents a partial write.
    // Asserting reset during RESP suppresses the response.
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_in_resp   = (r_state == ST_RESP) && !i_reset;

    assign o_mem_addr  = w_in_access ? r_addr  : '0;
    assign o_mem_wdata = w_in_access ? r_wdata : '0;
    assign o_mem_read  = w_in_access && !r_write && !i_reset;
    assign o_mem_write = w_in_access &&  r_write && !i_reset;

    assign o_rsp0_valid = w_in_resp && !r_owner;
    assign o_rsp1_valid = w_in_resp &&  r_owner;
    assign o_rsp0_rdata = o_rsp0_valid ? r_rdata : '0;
    assign o_rsp1_rdata = o_rsp1_valid ? r_rdata : '0;

    assign o_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int PRIO_REQ = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [31:0] rsp0_rdata, rsp1_rdata;
    wire  [31:0] mem_addr, mem_wdata, mem_rdata;
    wire         mem_read, mem_write;
    wire  [1:0]  dut_state;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_REQ(PRIO_REQ)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req0_valid (req_valid[0]),
        .i_req0_write (req_write[0]),
        .i_req0_addr  (req_addr[0]),
        .i_req0_wdata (req_wdata[0]),
        .o_req0_ready (req_ready[0]),
        .i_req1_valid (req_valid[1]),
        .i_req1_write (req_write[1]),
        .i_req1_addr  (req_addr[1]),
        .i_req1_wdata (req_wdata[1]),
        .o_req1_ready (req_ready[1]),
        .o_rsp0_valid (rsp_valid[0]),
        .o_rsp0_rdata (rsp0_rdata),
        .o_rsp1_valid (rsp_valid[1]),
        .o_rsp1_rdata (rsp1_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .i_mem_rdata  (mem_rdata),
        .o_state      (dut_state)
    );

    wire [133:0] all_out = {req_ready, rsp_valid, rsp0_rdata, rsp1_rdata,
                            mem_addr, mem_wdata, mem_read, mem_write};

    // ---------------- environment memory (256 words) ----------------
    logic [31:0] mem_arr [256];
    assign mem_rdata = mem_arr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [256];
    int          ref_last;
    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int exp_winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return 1 - ref_last;
`else
            return PRIO_REQ;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem_arr[idx] = val;
        ref_mem[idx] = val;
    endtask

    // ---------------- driver: one transaction, collects observations ----------------
    task automatic run_txn(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int acc_wait, output int strobe_k, output int rd_cnt,
                           output int wr_cnt, output logic [31:0] seen_addr,
                           output logic [31:0] seen_wdata, output int rsp_k,
                           output logic [31:0] rsp_data, output int wrong_rsp);
        acc_wait = -1; strobe_k = -1; rd_cnt = 0; wr_cnt = 0; rsp_k = -1;
        seen_addr = '1; seen_wdata = '1; rsp_data = '1; wrong_rsp = 0;
        @(negedge clk);
        req_valid[r] = 1'b1; req_write[r] = wr; req_addr[r] = a; req_wdata[r] = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[r]) begin
                acc_wait = i;
                break;
            end
            @(negedge clk);
        end
        if (acc_wait < 0) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk);
        ref_last = r;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Disturb the requester fields after acceptance.
                req_valid[r] = 1'b0; req_addr[r] = a ^ 32'h30;
                req_wdata[r] = ~d;   req_write[r] = ~wr;
            end
            #1;
            if ((mem_read || mem_write) && strobe_k < 0) begin
                strobe_k = k; seen_addr = mem_addr; seen_wdata = mem_wdata;
            end
            rd_cnt += int'(mem_read);
            wr_cnt += int'(mem_write);
            if (rsp_valid[r] && rsp_k < 0) begin
                rsp_k = k;
                rsp_data = (r == 0) ? rsp0_rdata : rsp1_rdata;
            end
            if (rsp_valid[1-r]) wrong_rsp++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11; req_write = 2'b01;
        req_addr[0] = $urandom; req_addr[1] = $urandom;
        req_wdata[0] = $urandom; req_wdata[1] = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_vec++;
            if (all_out !== '0) begin
                n_err++; $display("FAIL reset_outputs: got %h want 0", all_out);
            end
            n_vec++;
            if (dut_state !== 2'd0) begin
                n_err++; $display("FAIL reset_state: got %0d want 0", dut_state);
            end
        end
        req_valid = 2'b00;
        reset = 1'b0;
        ref_last = 1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_vec++;
            if (all_out !== '0 || dut_state !== 2'd0) begin
                n_err++; $display("FAIL idle_quiet: outputs %h state %0d want 0 0", all_out, dut_state);
            end
        end
    endtask

    task automatic test_basic_read();
        int aw, sk, rc, wc, rk, wrsp;
        logic [31:0] sa, sw, rd;
        preload(0, 32'h20040005);
        run_txn(0, 1'b0, 32'h0, 32'h0, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
        n_vec++; if (aw !== 0)  begin n_err++; $display("FAIL basic_ready_wait: got %0d want 0", aw); end
        n_vec++; if (sk !== 1 || rc !== 1 || wc !== 0) begin
            n_err++; $display("FAIL basic_strobe: k %0d rd %0d wr %0d want 1 1 0", sk, rc, wc); end
        n_vec++; if (sa !== 32'h0) begin n_err++; $display("FAIL basic_addr: got %h want 0", sa); end
        n_vec++; if (rk !== 2)  begin n_err++; $display("FAIL basic_latency: got %0d want 2", rk); end
        n_vec++; if (rd !== ref_mem[0]) begin n_err++; $display("FAIL basic_rdata: got %h want %h", rd, ref_mem[0]); end
        n_vec++; if (wrsp !== 0) begin n_err++; $display("FAIL basic_other_rsp: got %0d want 0", wrsp); end
    endtask

    task automatic test_write_read();
        int aw, sk, rc, wc, rk, wrsp;
        logic [31:0] sa, sw, rd;
        run_txn(1, 1'b1, 32'h80, 32'hDEADBEEF, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
        ref_mem[32] = 32'hDEADBEEF;
        n_vec++; if (wc !== 1 || rc !== 0 || sk !== 1) begin
            n_err++; $display("FAIL wr_strobe: wr %0d rd %0d k %0d want 1 0 1", wc, rc, sk); end
        n_vec++; if (sa !== 32'h80 || sw !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL wr_bus: addr %h data %h want 80 deadbeef", sa, sw); end
        n_vec++; if (rk !== 2 || rd !== 32'h0) begin
            n_err++; $display("FAIL wr_rsp: k %0d data %h want 2 0", rk, rd); end
        n_vec++; if (wrsp !== 0) begin n_err++; $display("FAIL wr_other_rsp: got %0d want 0", wrsp); end
        run_txn(1, 1'b0, 32'h80, 32'h0, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
        n_vec++; if (rk !== 2 || rd !== ref_mem[32]) begin
            n_err++; $display("FAIL rd_after_wr: k %0d data %h want 2 %h", rk, rd, ref_mem[32]); end
    endtask

    task automatic test_contention();
        int got, w;
        logic [1:0] exp_rdy;
        logic [31:0] exp_d, act_d;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = 1'b1; req_write[r] = 1'b0;
            req_addr[r] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        end
        for (int t = 0; t < 6; t++) begin
            got = -1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (|req_ready) begin got = i; break; end
            end
            n_vec++;
            if (got !== 0) begin
                n_err++; $display("FAIL tie_grant_wait: txn %0d got %0d want 0", t, got);
                break;
            end
            w = exp_winner(1'b1, 1'b1);
            exp_rdy = (w == 1) ? 2'b10 : 2'b01;
            n_vec++;
            if (req_ready !== exp_rdy) begin
                n_err++; $display("FAIL tie_grant: txn %0d ready %b want %b", t, req_ready, exp_rdy);
            end
            exp_q.push_back(ref_mem[req_addr[w][9:2]]);
            @(posedge clk);
            ref_last = w;
            #1;
            req_addr[w] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            @(negedge clk);
            n_vec++;
            if (req_ready !== 2'b00) begin
                n_err++; $display("FAIL tie_ready_busy: ready %b want 00", req_ready);
            end
            @(negedge clk);
            exp_d = exp_q.pop_front();
            act_d = (w == 1) ? rsp1_rdata : rsp0_rdata;
            n_vec++;
            if (rsp_valid !== exp_rdy || act_d !== exp_d) begin
                n_err++; $display("FAIL tie_rsp: txn %0d valid %b data %h want %b %h", t, rsp_valid, act_d, exp_rdy, exp_d);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_abort();
        int aw, sk, rc, wc, rk, wrsp;
        logic [31:0] sa, sw, rd;
        preload(33, 32'h11111111);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h84; req_wdata[0] = 32'h22222222;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL abort_accept: ready %b want 01", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        #1;
        n_vec++;
        if (mem_write !== 1'b0 || rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL abort_access: mem_write %b rsp %b want 0 00", mem_write, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        ref_last = 1;
        #1;
        n_vec++;
        if (dut_state !== 2'd0) begin n_err++; $display("FAIL abort_state: got %0d want 0", dut_state); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_vec++;
            if (rsp_valid !== 2'b00 || mem_write !== 1'b0) begin
                n_err++; $display("FAIL abort_quiet: rsp %b mem_write %b want 00 0", rsp_valid, mem_write);
            end
        end
        run_txn(0, 1'b0, 32'h84, 32'h0, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
        n_vec++;
        if (rk !== 2 || rd !== ref_mem[33]) begin
            n_err++; $display("FAIL abort_readback: k %0d data %h want 2 %h", rk, rd, ref_mem[33]);
        end
    endtask

    task automatic test_addr_change();
        int aw, sk, rc, wc, rk, wrsp;
        logic [31:0] sa, sw, rd;
        preload(4, $urandom);
        preload(8, ~ref_mem[4]);
        run_txn(0, 1'b0, 32'h10, 32'h0, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
        n_vec++; if (sa !== 32'h10) begin n_err++; $display("FAIL latch_addr: got %h want 10", sa); end
        n_vec++; if (rd !== ref_mem[4]) begin n_err++; $display("FAIL latch_rdata: got %h want %h", rd, ref_mem[4]); end
    endtask

    task automatic test_random();
        int aw, sk, rc, wc, rk, wrsp, r, idx;
        logic wr;
        logic [31:0] a, d, sa, sw, rd, exp_d;
        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 1);
            wr  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 255);
            a   = {22'd0, 8'(idx), 2'($urandom_range(0, 3))};
            d   = $urandom;
            exp_q.push_back(wr ? 32'h0 : ref_mem[idx]);
            if (wr) ref_mem[idx] = d;
            run_txn(r, wr, a, d, aw, sk, rc, wc, sa, sw, rk, rd, wrsp);
            exp_d = exp_q.pop_front();
            n_vec++;
            if (aw !== 0 || sk !== 1 || rk !== 2) begin
                n_err++; $display("FAIL rnd_timing: txn %0d wait %0d strobe %0d rsp %0d want 0 1 2", t, aw, sk, rk);
            end
            n_vec++;
            if (rc !== int'(!wr) || wc !== int'(wr)) begin
                n_err++; $display("FAIL rnd_strobe: txn %0d rd %0d wr %0d want %0d %0d", t, rc, wc, !wr, wr);
            end
            n_vec++;
            if (sa !== a || (wr && sw !== d)) begin
                n_err++; $display("FAIL rnd_bus: txn %0d addr %h data %h want %h %h", t, sa, sw, a, d);
            end
            n_vec++;
            if (rd !== exp_d || wrsp !== 0) begin
                n_err++; $display("FAIL rnd_rsp: txn %0d data %h other %0d want %h 0", t, rd, wrsp, exp_d);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        req_valid = 2'b00; req_write = 2'b00;
        req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        test_reset();
        test_idle();
        test_basic_read();
        test_write_read();
        test_contention();
        test_reset_abort();
        test_addr_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d comparisons done", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
